register_access_stage: RTL

- Parametrised successor to the bypass register-access stage.
- Adds a real one-entry pipestage with valid/ready handshake between decode and address generation.
- Adds a per-register in-flight-write scoreboard that stalls decode on read-after-write hazards. Writeback retires entries.
- Register index space is unified: GPR, segment and MMX registers. Register file storage stays outside this block; the stage carries an opaque payload.

---
 rtl/register_access_pkg.sv | 58 +++++
 rtl/reg_scoreboard.sv | 69 ++++++
 rtl/register_access_stage.sv | 94 +++++++++
 3 files changed

// File: rtl/register_access_pkg.sv
// Unified register index space shared by decode, writeback and the access stage.
// GPRs occupy 0-7, segment registers 8-13 and MMX registers 14-21.
package register_access_pkg;

    localparam int NUM_REGS_DEFAULT = 22;
    localparam int IDX_W_DEFAULT    = 5;
    localparam int CNT_W_DEFAULT    = 2;

    typedef logic [IDX_W_DEFAULT-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        RC_GPR = 2'd0,
        RC_SEG = 2'd1,
        RC_MMX = 2'd2
    } reg_class_e;

    localparam reg_idx_t REG_EAX = 5'd0;
    localparam reg_idx_t REG_ECX = 5'd1;
    localparam reg_idx_t REG_EDX = 5'd2;
    localparam reg_idx_t REG_EBX = 5'd3;
    localparam reg_idx_t REG_ESP = 5'd4;
    localparam reg_idx_t REG_EBP = 5'd5;
    localparam reg_idx_t REG_ESI = 5'd6;
    localparam reg_idx_t REG_EDI = 5'd7;

    localparam reg_idx_t SEG_ES = 5'd8;
    localparam reg_idx_t SEG_CS = 5'd9;
    localparam reg_idx_t SEG_SS = 5'd10;
    localparam reg_idx_t SEG_DS = 5'd11;
    localparam reg_idx_t SEG_FS = 5'd12;
    localparam reg_idx_t SEG_GS = 5'd13;

    localparam reg_idx_t MMX_MM0 = 5'd14;
    localparam reg_idx_t MMX_MM1 = 5'd15;
    localparam reg_idx_t MMX_MM2 = 5'd16;
    localparam reg_idx_t MMX_MM3 = 5'd17;
    localparam reg_idx_t MMX_MM4 = 5'd18;
    localparam reg_idx_t MMX_MM5 = 5'd19;
    localparam reg_idx_t MMX_MM6 = 5'd20;
    localparam reg_idx_t MMX_MM7 = 5'd21;

    // Beyond the scoreboarded range, so the stage never tracks it.
    localparam reg_idx_t REG_NONE = 5'd31;

    // Segment numbers 6 and 7 do not exist and map to REG_NONE rather than aliasing MMX.
    function automatic reg_idx_t reg_index(input reg_class_e cls, input logic [2:0] num);
        reg_idx_t idx;
        idx = REG_NONE;
        case (cls)
            RC_GPR: idx = REG_EAX + reg_idx_t'(num);
            RC_SEG: idx = (num < 3'd6) ? SEG_ES + reg_idx_t'(num) : REG_NONE;
            RC_MMX: idx = MMX_MM0 + reg_idx_t'(num);
            default: idx = REG_NONE;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write counters: issue increments, writeback retires.
// Produces the busy vector, the destination-saturated flag and the underflow pulse.
module reg_scoreboard
    import register_access_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEFAULT,
    parameter int IDX_W    = IDX_W_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                inc_en,
    input  logic [IDX_W-1:0]    inc_reg,
    input  logic                dst_valid,
    input  logic [IDX_W-1:0]    dst_reg,
    input  logic                wb_en,
    input  logic [IDX_W-1:0]    wb_reg,
    output logic [NUM_REGS-1:0] busy,
    output logic                dst_full,
    output logic                underflow
);

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic                wb_hit_zero;

    // Index decode by comparison keeps out-of-range indices from touching any counter.
    always_comb begin
        busy        = '0;
        inc_vec     = '0;
        dec_vec     = '0;
        dst_full    = 1'b0;
        wb_hit_zero = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy[i]    = (cnt[i] != '0);
            inc_vec[i] = inc_en && (inc_reg == IDX_W'(i));
            dec_vec[i] = wb_en && (wb_reg == IDX_W'(i)) && (cnt[i] != '0);
            if (dst_valid && (dst_reg == IDX_W'(i)) && (cnt[i] == {CNT_W{1'b1}})) begin
                dst_full = 1'b1;
            end
            if (wb_en && (wb_reg == IDX_W'(i)) && (cnt[i] == '0)) begin
                wb_hit_zero = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underflow <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            underflow <= wb_hit_zero && !flush;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (flush) begin
                    cnt[i] <= '0;
                end else if (inc_vec[i] && !dec_vec[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/register_access_stage.sv
// One-entry decode-to-address-generation pipestage gated by a read-after-write scoreboard.
// The payload is carried opaquely; register values are read downstream once no write is pending.
module register_access_stage
    import register_access_pkg::*;
#(
    parameter int PAYLOAD_W = 256,
    parameter int NUM_REGS  = NUM_REGS_DEFAULT,
    parameter int IDX_W     = IDX_W_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 d_valid,
    output logic                 d_ready,
    input  logic [PAYLOAD_W-1:0] d_payload,
    input  logic [NUM_REGS-1:0]  d_src_mask,
    input  logic                 d_dst_valid,
    input  logic [IDX_W-1:0]     d_dst_reg,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic [PAYLOAD_W-1:0] r_payload,
    output logic                 r_dst_valid,
    output logic [IDX_W-1:0]     r_dst_reg,
    input  logic                 wb_en,
    input  logic [IDX_W-1:0]     wb_reg,
    output logic [NUM_REGS-1:0]  busy,
    output logic                 sb_underflow,
    output logic [31:0]          stall_cycles
);

    logic hazard;
    logic dst_full;
    logic slot_free;
    logic issue;

    // Handshake: a transfer happens on a clock edge where valid and ready are both high.
    // A producer holds valid and its data until that edge; ready never depends on the
    // same-side valid. Hazards use registered counts only, so a same-cycle writeback
    // does not release a waiting reader until the following cycle.
    always_comb begin
        hazard    = |(d_src_mask & busy);
        slot_free = !r_valid || r_ready;
        d_ready   = !reset && !flush && !hazard && !dst_full && slot_free;
        issue     = d_valid && d_ready;
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .CNT_W    (CNT_W)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .inc_en    (issue && d_dst_valid),
        .inc_reg   (d_dst_reg),
        .dst_valid (d_dst_valid),
        .dst_reg   (d_dst_reg),
        .wb_en     (wb_en),
        .wb_reg    (wb_reg),
        .busy      (busy),
        .dst_full  (dst_full),
        .underflow (sb_underflow)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_payload   <= '0;
            r_dst_valid <= 1'b0;
            r_dst_reg   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (issue) begin
            r_valid     <= 1'b1;
            r_payload   <= d_payload;
            r_dst_valid <= d_dst_valid;
            r_dst_reg   <= d_dst_reg;
        end else if (r_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Flush cycles are not stalls even though d_ready is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (d_valid && !d_ready && !flush) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule
